// File: rtl/wb_port_scheduler.sv
// Shares the single register-file write port between ALU writebacks and W loads.
// Loads own the port in their capture cycle; ALU writes to W wait behind a pending load.
module wb_port_scheduler #(
   parameter int DATA_W    = 16,
   parameter int SEL_W     = 6,
   parameter int MEM_LAT   = 2,
   parameter int W_REG_SEL = 34
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              alu_valid,
   input  logic [DATA_W-1:0] alu_data,
   input  logic [SEL_W-1:0]  alu_sel,
   output logic              alu_stall,
   input  logic              mr,
   output logic              mr_ready,
   output logic              mem_rd_en,
   input  logic [DATA_W-1:0] mem_rd_data,
   output logic              wb_en,
   output logic [DATA_W-1:0] wb_data,
   output logic [SEL_W-1:0]  wb_sel,
   output logic              busy,
   output logic              update_flag
);

   localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);
   localparam logic [SEL_W-1:0] W_SEL = SEL_W'(W_REG_SEL);

   typedef enum logic {
      IDLE,
      MEM_WAIT
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             capture;
   logic             waw;
   logic             alu_fire;

   assign capture   = (state == MEM_WAIT) && (cnt == '0);
   assign waw       = (state == MEM_WAIT) && alu_valid && (alu_sel == W_SEL);
   assign alu_stall = capture | waw;
   assign alu_fire  = alu_valid & ~alu_stall;
   assign mr_ready  = (state == IDLE);
   assign mem_rd_en = mr & mr_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         busy        <= 1'b0;
         wb_en       <= 1'b0;
         wb_data     <= '0;
         wb_sel      <= '0;
         update_flag <= 1'b0;
      end else begin
         wb_en <= 1'b0;
         unique case (state)
            IDLE: begin
               if (mr) begin
                  state <= MEM_WAIT;
                  cnt   <= CNT_INIT;
                  busy  <= 1'b1;
               end
            end
            MEM_WAIT: begin
               if (cnt != '0) begin
                  cnt <= cnt - CNT_W'(1);
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
         endcase
         // Load wins the port; a stalled ALU request retries next cycle.
         if (capture) begin
            wb_en       <= 1'b1;
            wb_data     <= mem_rd_data;
            wb_sel      <= W_SEL;
            update_flag <= ~update_flag;
         end else if (alu_fire) begin
            wb_en       <= 1'b1;
            wb_data     <= alu_data;
            wb_sel      <= alu_sel;
            update_flag <= ~update_flag;
         end
      end
   end

endmodule

// File: tb/tb_wb_port_scheduler.sv
// Bench for wb_port_scheduler: vector table plus hand sequences,
// writes checked against an ordered queue of expected port writes.
module tb_wb_port_scheduler;

   localparam int DW  = 16;
   localparam int SW  = 6;
   localparam int LAT = 2;
   localparam int WR  = 34;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          alu_valid = 1'b0;
   logic [DW-1:0] alu_data = '0;
   logic [SW-1:0] alu_sel = '0;
   logic          alu_stall;
   logic          mr = 1'b0;
   logic          mr_ready;
   logic          mem_rd_en;
   logic [DW-1:0] mem_rd_data = '0;
   logic          wb_en;
   logic [DW-1:0] wb_data;
   logic [SW-1:0] wb_sel;
   logic          busy;
   logic          update_flag;

   wb_port_scheduler #(
      .DATA_W(DW), .SEL_W(SW), .MEM_LAT(LAT), .W_REG_SEL(WR)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .alu_valid(alu_valid), .alu_data(alu_data), .alu_sel(alu_sel),
      .alu_stall(alu_stall),
      .mr(mr), .mr_ready(mr_ready), .mem_rd_en(mem_rd_en),
      .mem_rd_data(mem_rd_data),
      .wb_en(wb_en), .wb_data(wb_data), .wb_sel(wb_sel),
      .busy(busy), .update_flag(update_flag)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] data;
      logic [SW-1:0] sel;
   } wr_t;

   typedef struct {
      logic          av;
      logic [DW-1:0] ad;
      logic [SW-1:0] as;
      logic          mr;
      logic [DW-1:0] md;
      logic          exp_stall;
      logic          exp_rd_en;
   } vec_t;

   wr_t           exp_q[$];
   logic          exp_flag = 1'b0;
   logic [DW-1:0] last_data = '0;
   logic [SW-1:0] last_sel = '0;
   int            checks = 0;
   int            failures = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push(input logic [DW-1:0] d, input logic [SW-1:0] s);
      wr_t w;
      w.data = d;
      w.sel  = s;
      exp_q.push_back(w);
   endtask

   // Inputs change 2ns after each rising edge; the monitor samples at 1ns.
   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic clear_in();
      alu_valid = 1'b0;
      alu_data  = '0;
      alu_sel   = '0;
      mr        = 1'b0;
   endtask

   always @(posedge clk) begin
      wr_t e;
      #1;
      if (wb_en) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL wb_unexpected: got %0h/%0d expected no write at %0t",
                     wb_data, wb_sel, $time);
         end else begin
            e = exp_q.pop_front();
            chk("wb_data", 32'(wb_data), 32'(e.data));
            chk("wb_sel", 32'(wb_sel), 32'(e.sel));
            last_data = e.data;
            last_sel  = e.sel;
         end
         exp_flag = ~exp_flag;
      end else begin
         chk("hold_data", 32'(wb_data), 32'(last_data));
         chk("hold_sel", 32'(wb_sel), 32'(last_sel));
      end
      chk("update_flag", 32'(update_flag), 32'(exp_flag));
   end

   vec_t vecs[6];

   initial begin
      vecs[0] = '{1'b1, 16'h1234, 6'd5,  1'b0, 16'h0000, 1'b0, 1'b0};
      vecs[1] = '{1'b1, 16'hFFFF, 6'd63, 1'b0, 16'h0000, 1'b0, 1'b0};
      vecs[2] = '{1'b1, 16'hC0DE, 6'd34, 1'b0, 16'h0000, 1'b0, 1'b0};
      vecs[3] = '{1'b0, 16'h0000, 6'd0,  1'b1, 16'hBEEF, 1'b0, 1'b1};
      vecs[4] = '{1'b1, 16'h0303, 6'd3,  1'b1, 16'h4321, 1'b0, 1'b1};
      vecs[5] = '{1'b1, 16'h3434, 6'd34, 1'b1, 16'h8001, 1'b0, 1'b1};

      // Reset state
      clear_in();
      cyc();
      cyc();
      chk("rst_wb_en", 32'(wb_en), 0);
      chk("rst_wb_data", 32'(wb_data), 0);
      chk("rst_wb_sel", 32'(wb_sel), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_flag", 32'(update_flag), 0);
      rst_n = 1'b1;
      #1;
      chk("rst_mr_ready", 32'(mr_ready), 1);
      cyc();

      // Table: issue from IDLE, then ride out any load
      foreach (vecs[i]) begin
         alu_valid = vecs[i].av;
         alu_data  = vecs[i].ad;
         alu_sel   = vecs[i].as;
         mr        = vecs[i].mr;
         #1;
         chk("v_stall", 32'(alu_stall), 32'(vecs[i].exp_stall));
         chk("v_rd_en", 32'(mem_rd_en), 32'(vecs[i].exp_rd_en));
         chk("v_ready", 32'(mr_ready), 1);
         if (vecs[i].av) push(vecs[i].ad, vecs[i].as);
         if (vecs[i].mr) push(vecs[i].md, 6'(WR));
         cyc();
         alu_valid   = 1'b0;
         mem_rd_data = vecs[i].md;
         if (vecs[i].mr) begin
            for (int k = 0; k < LAT; k++) begin
               #1;
               chk("w_busy", 32'(busy), 1);
               chk("w_ready", 32'(mr_ready), 0);
               chk("w_rd_en", 32'(mem_rd_en), 0);
               chk("w_stall", 32'(alu_stall), 32'(k == LAT - 1));
               cyc();
            end
            mr = 1'b0;
            chk("ld_done_busy", 32'(busy), 0);
            chk("ld_done_ready", 32'(mr_ready), 1);
         end
         cyc();
      end

      // Port conflict: ALU request lands in the capture cycle
      mr = 1'b1;
      push(16'hBEEF, 6'(WR));
      cyc();
      mr = 1'b0;
      mem_rd_data = 16'hBEEF;
      for (int k = 0; k < LAT - 1; k++) cyc();
      alu_valid = 1'b1;
      alu_data  = 16'h00AA;
      alu_sel   = 6'd7;
      #1;
      chk("conf_stall", 32'(alu_stall), 1);
      cyc();
      chk("conf_release", 32'(alu_stall), 0);
      push(16'h00AA, 6'd7);
      cyc();
      clear_in();
      cyc();

      // WAW: ALU write to W held until the load lands
      mr = 1'b1;
      mem_rd_data = 16'h7777;
      push(16'h7777, 6'(WR));
      cyc();
      mr = 1'b0;
      alu_valid = 1'b1;
      alu_data  = 16'h5A5A;
      alu_sel   = 6'(WR);
      for (int k = 0; k < 16; k++) begin
         #1;
         if (!busy) break;
         chk("waw_stall", 32'(alu_stall), 1);
         cyc();
      end
      chk("waw_bound", 32'(busy), 0);
      chk("waw_release", 32'(alu_stall), 0);
      push(16'h5A5A, 6'(WR));
      cyc();
      clear_in();
      cyc();

      // Non-W ALU write passes a pending load
      mr = 1'b1;
      mem_rd_data = 16'h1111;
      cyc();
      mr = 1'b0;
      alu_valid = 1'b1;
      alu_data  = 16'h0909;
      alu_sel   = 6'd9;
      #1;
      chk("pass_stall", 32'(alu_stall), 0);
      push(16'h0909, 6'd9);
      push(16'h1111, 6'(WR));
      cyc();
      clear_in();
      for (int k = 0; k < LAT; k++) cyc();

      // Reset mid-load: pending load dropped
      mr = 1'b1;
      mem_rd_data = 16'hDEAD;
      push(16'hDEAD, 6'(WR));
      cyc();
      mr = 1'b0;
      rst_n = 1'b0;
      exp_q.delete();
      exp_flag  = 1'b0;
      last_data = '0;
      last_sel  = '0;
      #1;
      chk("mrst_wb_en", 32'(wb_en), 0);
      chk("mrst_busy", 32'(busy), 0);
      chk("mrst_flag", 32'(update_flag), 0);
      chk("mrst_data", 32'(wb_data), 0);
      cyc();
      cyc();
      rst_n = 1'b1;
      #1;
      chk("mrst_ready", 32'(mr_ready), 1);
      for (int k = 0; k < 4; k++) cyc();

      chk("queue_empty", 32'(exp_q.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
